ioport_unit: RTL

//   Memory-mapped I/O port responder behind the data-bus address decoder (M=1 window, 0x2000-0x200C).

---
 rtl/ioport_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/ioport_unit.sv
// ioport_unit: memory-mapped I/O responder (0x2000-0x200C) with two output registers, a debounced input port and sticky rising-edge flags.
// Define IOPORT_IRQ_EN to add the registered irq output (irq = |flags, one cycle late).
module ioport_unit #(
  parameter int NIN             = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      ioport_we,
  input  logic [1:0]      ioport_rd_sel,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  output logic [31:0]     out0,
  output logic [31:0]     out1,
  input  logic [NIN-1:0]  in_raw
`ifdef IOPORT_IRQ_EN
  ,
  output logic            irq
`endif
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NIN-1:0] sync1, sync2;
  logic [NIN-1:0] samp, deb, deb_prev, flags;
  logic [NIN-1:0] stable, rise, flags_clr;
  logic [CW-1:0]  tick_cnt;
  logic           tick;
  logic [31:0]    deb_ext, flags_ext;
  logic           port2_we_unused;

  // Port 2 is read-only; its write strobe is intentionally dropped.
  assign port2_we_unused = ioport_we[2];

  assign tick      = (tick_cnt == TICK_LAST);
  assign stable    = ~(sync2 ^ samp);
  assign rise      = deb & ~deb_prev;
  assign flags_clr = ioport_we[3] ? wd[NIN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      out0 <= '0;
      out1 <= '0;
    end else begin
      if (ioport_we[0]) out0 <= wd;
      if (ioport_we[1]) out1 <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  // A bit only reaches deb once it has read the same at two consecutive ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp <= '0;
      deb  <= '0;
    end else if (tick) begin
      samp <= sync2;
      deb  <= (stable & sync2) | (~stable & deb);
    end
  end

  // Rise is OR'd in after the clear so a simultaneous set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_prev <= '0;
      flags    <= '0;
    end else begin
      deb_prev <= deb;
      flags    <= (flags & ~flags_clr) | rise;
    end
  end

`ifdef IOPORT_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |flags;
    end
  end
`endif

  always_comb begin
    deb_ext              = '0;
    flags_ext            = '0;
    deb_ext[NIN-1:0]     = deb;
    flags_ext[NIN-1:0]   = flags;
    rd                   = '0;
    case (ioport_rd_sel)
      2'd0:    rd = out0;
      2'd1:    rd = out1;
      2'd2:    rd = deb_ext;
      default: rd = flags_ext;
    endcase
  end

endmodule
